// File: rtl/sound_pkg.sv
// Shared types and defaults for the sound-CPU / GA20 SDRAM arbiter.
package sound_pkg;

  typedef enum logic {PORT_SAMPLE, PORT_CPU} port_e;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} arb_state_e;

  localparam logic [24:0] SAMPLE_BASE_DEF = 25'h0100000;
  localparam logic [24:0] ROM_BASE_DEF    = 25'h0000000;

  // 8-byte line address within a port region; the sum wraps at 2^25.
  function automatic logic [24:0] sdr_line_addr(input logic [24:0] base,
                                                input logic [19:0] addr);
    return base + {5'd0, addr[19:3], 3'b000};
  endfunction

endpackage

// File: rtl/sound_sdr_arbiter.sv
// Two-port (GA20 sample / sound CPU ROM) arbiter onto a single SDRAM read port,
// one transaction in flight, sample port favoured with bounded CPU starvation.
module sound_sdr_arbiter
  import sound_pkg::*;
#(
  parameter logic [24:0] SAMPLE_BASE = SAMPLE_BASE_DEF,
  parameter logic [24:0] ROM_BASE    = ROM_BASE_DEF,
  parameter int          STARVE_MAX  = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        s_req,
  input  logic [19:0] s_addr,
  output logic        s_ack,
  output logic [63:0] s_data,
  input  logic        c_req,
  input  logic [19:0] c_addr,
  output logic        c_ack,
  output logic [63:0] c_data,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic [63:0] sdr_data,
  input  logic        sdr_rdy
);

  localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  arb_state_e    state, state_nxt;
  port_e         winner;
  logic [SW-1:0] starve;
  logic          any_req;
  logic          grant_cpu;

  assign any_req   = s_req | c_req;
  // CPU wins outright when alone, or when it has been passed over too often.
  assign grant_cpu = c_req & (~s_req | (starve == STARVE_SAT));

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (sdr_rdy) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      winner   <= PORT_SAMPLE;
      starve   <= '0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      s_ack    <= 1'b0;
      c_ack    <= 1'b0;
      s_data   <= '0;
      c_data   <= '0;
    end else begin
      s_ack <= 1'b0;
      c_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!c_req || grant_cpu)   starve <= '0;
          else if (starve != STARVE_SAT) starve <= starve + SW'(1);
          if (any_req) begin
            winner   <= grant_cpu ? PORT_CPU : PORT_SAMPLE;
            sdr_req  <= 1'b1;
            sdr_addr <= grant_cpu ? sdr_line_addr(ROM_BASE, c_addr)
                                  : sdr_line_addr(SAMPLE_BASE, s_addr);
          end
        end
        BUSY: begin
          if (sdr_rdy) begin
            sdr_req <= 1'b0;
            if (winner == PORT_CPU) begin
              c_data <= sdr_data;
              c_ack  <= 1'b1;
            end else begin
              s_data <= sdr_data;
              s_ack  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_sdr_arbiter.sv
// Scoreboard bench for sound_sdr_arbiter: expected grants queued as requests are raised.
module tb_sound_sdr_arbiter;
  import sound_pkg::*;

  localparam logic [24:0] SB = 25'h0100000;
  localparam logic [24:0] RB = 25'h1FFFFF8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        s_req, c_req, s_ack, c_ack, sdr_req, sdr_rdy;
  logic [19:0] s_addr, c_addr;
  logic [63:0] s_data, c_data, sdr_data;
  logic [24:0] sdr_addr;

  typedef struct {
    port_e       port;
    logic [24:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] last_s = '0;
  logic [63:0] last_c = '0;

  sound_sdr_arbiter #(.SAMPLE_BASE(SB), .ROM_BASE(RB), .STARVE_MAX(3)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .s_req(s_req), .s_addr(s_addr), .s_ack(s_ack), .s_data(s_data),
    .c_req(c_req), .c_addr(c_addr), .c_ack(c_ack), .c_data(c_data),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_data(sdr_data), .sdr_rdy(sdr_rdy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  // base + line-aligned offset, truncated to the 25-bit SDRAM space
  function automatic logic [24:0] line_addr(input logic [24:0] base, input logic [19:0] a);
    logic [25:0] sum;
    sum = {1'b0, base} + {6'd0, a[19:3], 3'b000};
    return sum[24:0];
  endfunction

  task automatic push(input port_e p, input logic [19:0] a);
    exp_t e;
    e.port = p;
    e.addr = line_addr((p == PORT_CPU) ? RB : SB, a);
    exp_q.push_back(e);
  endtask

  // Act as the SDRAM for one transaction: rdy after 'delay' extra BUSY cycles.
  task automatic serve(input int delay, input bit drop_s, input bit drop_c);
    int          t;
    exp_t        e;
    logic [24:0] a0;
    logic [63:0] d;
    t = 0;
    while (sdr_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (sdr_req !== 1'b1) begin
      check("sdr_req_timeout", {63'd0, sdr_req}, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_grant", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("sdr_addr", {39'd0, sdr_addr}, {39'd0, e.addr});
    a0 = sdr_addr;
    repeat (delay) begin
      tick();
      check("busy_hold", {36'd0, s_ack, c_ack, sdr_req, sdr_addr}, {36'd0, 2'b00, 1'b1, a0});
    end
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick();
    sdr_rdy  = 1'b0;
    sdr_data = ~d;
    check("ack_port", {62'd0, s_ack, c_ack}, (e.port == PORT_SAMPLE) ? 64'd2 : 64'd1);
    check("sdr_req_drop", {63'd0, sdr_req}, 64'd0);
    if (e.port == PORT_SAMPLE) last_s = d;
    else                       last_c = d;
    check("s_data", s_data, last_s);
    check("c_data", c_data, last_c);
    if (drop_s) s_req = 1'b0;
    if (drop_c) c_req = 1'b0;
    tick();
    check("ack_pulse", {62'd0, s_ack, c_ack}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1; s_req = 1'b0; c_req = 1'b0; s_addr = '0; c_addr = '0;
    sdr_rdy = 1'b0; sdr_data = '0;
    repeat (3) tick();
    check("rst_ctl", {61'd0, sdr_req, s_ack, c_ack}, 64'd0);
    check("rst_addr", {39'd0, sdr_addr}, 64'd0);
    check("rst_s_data", s_data, 64'd0);
    check("rst_c_data", c_data, 64'd0);
    reset = 1'b0;
    tick();

    // single sample read, rdy three cycles after request
    s_addr = 20'h00013; s_req = 1'b1;
    push(PORT_SAMPLE, 20'h00013);
    serve(3, 1'b1, 1'b0);

    // CPU read at top of range: base + offset wraps past 2^25
    c_addr = 20'hFFFFF; c_req = 1'b1;
    push(PORT_CPU, 20'hFFFFF);
    serve(0, 1'b0, 1'b1);

    // stray rdy while idle must be ignored
    repeat (2) tick();
    sdr_data = {$urandom, $urandom};
    sdr_rdy = 1'b1;
    tick();
    sdr_rdy = 1'b0;
    check("stray_ctl", {61'd0, sdr_req, s_ack, c_ack}, 64'd0);
    tick();
    check("stray_ack", {62'd0, s_ack, c_ack}, 64'd0);
    check("stray_s_data", s_data, last_s);
    check("stray_c_data", c_data, last_c);

    // both ports held: S,S,S,C repeating
    repeat (2) tick();
    s_addr = 20'h00040; c_addr = 20'h00100;
    s_req = 1'b1; c_req = 1'b1;
    for (int i = 0; i < 8; i++)
      push(((i % 4) == 3) ? PORT_CPU : PORT_SAMPLE, ((i % 4) == 3) ? 20'h00100 : 20'h00040);
    for (int i = 0; i < 8; i++)
      serve(i % 3, i == 7, i == 7);

    // reset while BUSY, then a late rdy
    repeat (2) tick();
    c_addr = 20'h00208; c_req = 1'b1;
    t = 0;
    while (sdr_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("rst_busy_entry", {63'd0, sdr_req}, 64'd1);
    reset = 1'b1; c_req = 1'b0;
    tick();
    reset = 1'b0;
    sdr_data = {$urandom, $urandom};
    sdr_rdy = 1'b1;
    tick();
    sdr_rdy = 1'b0;
    check("rst_busy_ctl", {61'd0, sdr_req, s_ack, c_ack}, 64'd0);
    check("rst_busy_addr", {39'd0, sdr_addr}, 64'd0);
    check("rst_busy_s_data", s_data, 64'd0);
    check("rst_busy_c_data", c_data, 64'd0);
    tick();
    check("rst_busy_ack", {62'd0, s_ack, c_ack}, 64'd0);
    last_s = '0; last_c = '0;

    // traffic resumes normally after the abandoned transaction
    s_addr = 20'hABCDF; s_req = 1'b1;
    push(PORT_SAMPLE, 20'hABCDF);
    serve(1, 1'b1, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
